// File: rtl/glb_load_sequencer_if.sv
// ---------------------------------------------------------------------------
// glb_load_sequencer_if : host stream / SRAM write-port bundle for the loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface glb_load_sequencer_if;
    logic        ready;
    logic [31:0] data_in;
    logic        compute_done;
    logic [31:0] wdata;
    logic        ifmap_we;
    logic [3:0]  ifmap_addr;
    logic        weight_we;
    logic [9:0]  weight_addr;
    logic        bias_we;
    logic [5:0]  bias_addr;
    logic        compute_start;
    logic        pass_idx;
    logic        busy;
    logic        layer_done;
    logic        protocol_err;

    modport master (
        output ready, data_in, compute_done,
        input  wdata, ifmap_we, ifmap_addr, weight_we, weight_addr,
               bias_we, bias_addr, compute_start, pass_idx, busy,
               layer_done, protocol_err
    );

    modport slave (
        input  ready, data_in, compute_done,
        output wdata, ifmap_we, ifmap_addr, weight_we, weight_addr,
               bias_we, bias_addr, compute_start, pass_idx, busy,
               layer_done, protocol_err
    );
endinterface

`default_nettype wire

// File: rtl/glb_load_sequencer.sv
// ---------------------------------------------------------------------------
// glb_load_sequencer : routes the host word stream into ifmap/weight/bias SRAMs
// and kicks off one accelerator pass per load. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module glb_load_sequencer #(
    parameter int IFMAP_WORDS  = 16,
    parameter int WEIGHT_WORDS = 1024,
    parameter int BIAS_WORDS   = 64,
    parameter int NUM_PASS     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    glb_load_sequencer_if.slave  bus
);

    localparam int MAX_IW    = (IFMAP_WORDS > BIAS_WORDS) ? IFMAP_WORDS : BIAS_WORDS;
    localparam int MAX_WORDS = (WEIGHT_WORDS > MAX_IW) ? WEIGHT_WORDS : MAX_IW;
    localparam int CNT_W     = $clog2(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_IF = 3'd1,
        S_LOAD_W  = 3'd2,
        S_LOAD_B  = 3'd3,
        S_START   = 3'd4,
        S_WAIT    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ifmap_we_q, ifmap_we_d;
    logic [3:0]         ifmap_addr_q, ifmap_addr_d;
    logic               weight_we_q, weight_we_d;
    logic [9:0]         weight_addr_q, weight_addr_d;
    logic               bias_we_q, bias_we_d;
    logic [5:0]         bias_addr_q, bias_addr_d;
    logic               start_q, start_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               layer_done_q, layer_done_d;
    logic               err_q, err_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wdata_d       = wdata_q;
        ifmap_we_d    = 1'b0;
        ifmap_addr_d  = ifmap_addr_q;
        weight_we_d   = 1'b0;
        weight_addr_d = weight_addr_q;
        bias_we_d     = 1'b0;
        bias_addr_d   = bias_addr_q;
        start_d       = 1'b0;
        pass_d        = pass_q;
        layer_done_d  = 1'b0;
        // A start request outside IDLE is flagged but otherwise has no effect
        err_d         = err_q | (bus.ready && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (bus.ready) begin
                    state_d = S_LOAD_IF;
                    cnt_d   = '0;
                end
            end
            S_LOAD_IF: begin
                wdata_d      = bus.data_in;
                ifmap_we_d   = 1'b1;
                ifmap_addr_d = cnt_q[3:0];
                if (cnt_q == CNT_W'(IFMAP_WORDS - 1)) begin
                    state_d = S_LOAD_W;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOAD_W: begin
                wdata_d       = bus.data_in;
                weight_we_d   = 1'b1;
                weight_addr_d = cnt_q[9:0];
                if (cnt_q == CNT_W'(WEIGHT_WORDS - 1)) begin
                    state_d = S_LOAD_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOAD_B: begin
                wdata_d     = bus.data_in;
                bias_we_d   = 1'b1;
                bias_addr_d = cnt_q[5:0];
                if (cnt_q == CNT_W'(BIAS_WORDS - 1)) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_START: begin
                start_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.compute_done) begin
                    state_d = S_IDLE;
                    if (32'(pass_q) < NUM_PASS - 1) begin
                        pass_d = pass_q + 1'b1;
                    end else begin
                        pass_d       = 1'b0;
                        layer_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wdata_q       <= '0;
            ifmap_we_q    <= 1'b0;
            ifmap_addr_q  <= '0;
            weight_we_q   <= 1'b0;
            weight_addr_q <= '0;
            bias_we_q     <= 1'b0;
            bias_addr_q   <= '0;
            start_q       <= 1'b0;
            pass_q        <= 1'b0;
            busy_q        <= 1'b0;
            layer_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wdata_q       <= wdata_d;
            ifmap_we_q    <= ifmap_we_d;
            ifmap_addr_q  <= ifmap_addr_d;
            weight_we_q   <= weight_we_d;
            weight_addr_q <= weight_addr_d;
            bias_we_q     <= bias_we_d;
            bias_addr_q   <= bias_addr_d;
            start_q       <= start_d;
            pass_q        <= pass_d;
            busy_q        <= busy_d;
            layer_done_q  <= layer_done_d;
            err_q         <= err_d;
        end
    end

    assign bus.wdata         = wdata_q;
    assign bus.ifmap_we      = ifmap_we_q;
    assign bus.ifmap_addr    = ifmap_addr_q;
    assign bus.weight_we     = weight_we_q;
    assign bus.weight_addr   = weight_addr_q;
    assign bus.bias_we       = bias_we_q;
    assign bus.bias_addr     = bias_addr_q;
    assign bus.compute_start = start_q;
    assign bus.pass_idx      = pass_q;
    assign bus.busy          = busy_q;
    assign bus.layer_done    = layer_done_q;
    assign bus.protocol_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_glb_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_glb_load_sequencer : directed self-checking bench for glb_load_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_glb_load_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    glb_load_sequencer_if bif ();

    glb_load_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One pass load: optional extra ready at rdy_k, spurious done at done_k,
    // reset assertion at abort_k (negative index disables each).
    task automatic run_load(input logic exp_pass, input int rdy_k, input int done_k,
                            input int abort_k);
        int   strobes;
        int   route_errs;
        logic e_if, e_w, e_b;
        strobes    = 0;
        route_errs = 0;
        bif.ready  = 1'b1;
        tick();
        bif.ready  = 1'b0;
        for (int k = 0; k < 1104; k++) begin
            bif.data_in      = 32'(k);
            bif.ready        = (k == rdy_k);
            bif.compute_done = (k == done_k);
            if (k == abort_k) rst = 1'b0;
            tick();
            bif.ready        = 1'b0;
            bif.compute_done = 1'b0;
            if (k == abort_k) begin
                rst = 1'b1;
                check("abort_strobes", {29'd0, bif.ifmap_we, bif.weight_we, bif.bias_we}, 32'd0);
                check("abort_busy", {31'd0, bif.busy}, 32'd0);
                check("abort_pass", {31'd0, bif.pass_idx}, 32'd0);
                check("abort_err", {31'd0, bif.protocol_err}, 32'd0);
                return;
            end
            e_if = (k < 16);
            e_w  = (k >= 16) && (k < 1040);
            e_b  = (k >= 1040);
            strobes += int'(bif.ifmap_we) + int'(bif.weight_we) + int'(bif.bias_we);
            if ({bif.ifmap_we, bif.weight_we, bif.bias_we} !== {e_if, e_w, e_b}) route_errs++;
            if (bif.wdata !== 32'(k)) route_errs++;
            if (bif.busy !== 1'b1 || bif.compute_start !== 1'b0) route_errs++;
            if (bif.pass_idx !== exp_pass) route_errs++;
            if (e_if && bif.ifmap_addr  !== 4'(k))         route_errs++;
            if (e_w  && bif.weight_addr !== 10'(k - 16))   route_errs++;
            if (e_b  && bif.bias_addr   !== 6'(k - 1040))  route_errs++;
            if (k == 0)    check("if_addr0",  {28'd0, bif.ifmap_addr}, 32'd0);
            if (k == 15)   check("if_addr15", {28'd0, bif.ifmap_addr}, 32'd15);
            if (k == 16)   check("w_addr0_data", bif.wdata, 32'd16);
            if (k == 1039) check("w_addr1023", {22'd0, bif.weight_addr}, 32'd1023);
            if (k == 1040) check("b_addr0_data", bif.wdata, 32'd1040);
            if (k == 1103) check("b_addr63", {26'd0, bif.bias_addr}, 32'd63);
        end
        check("strobe_count", 32'(strobes), 32'd1104);
        check("route_errs", 32'(route_errs), 32'd0);
        tick();
        check("cstart_high", {31'd0, bif.compute_start}, 32'd1);
        check("cstart_nostrobe", {29'd0, bif.ifmap_we, bif.weight_we, bif.bias_we}, 32'd0);
        check("cstart_busy", {31'd0, bif.busy}, 32'd1);
        tick();
        check("cstart_low", {31'd0, bif.compute_start}, 32'd0);
    endtask

    task automatic finish_pass(input logic exp_ld, input logic exp_pass);
        repeat (3) tick();
        check("wait_busy", {31'd0, bif.busy}, 32'd1);
        bif.compute_done = 1'b1;
        tick();
        bif.compute_done = 1'b0;
        check("done_busy", {31'd0, bif.busy}, 32'd0);
        check("done_layer", {31'd0, bif.layer_done}, {31'd0, exp_ld});
        check("done_pass", {31'd0, bif.pass_idx}, {31'd0, exp_pass});
        tick();
        check("layer_pulse_end", {31'd0, bif.layer_done}, 32'd0);
    endtask

    initial begin
        int quiet;
        rst              = 1'b0;
        bif.ready        = 1'b1;
        bif.compute_done = 1'b1;
        bif.data_in      = 32'hABCD_1234;
        tick();
        tick();
        check("rst_ctl", {24'd0, bif.ifmap_we, bif.weight_we, bif.bias_we, bif.compute_start,
                          bif.busy, bif.layer_done, bif.protocol_err, bif.pass_idx}, 32'd0);
        check("rst_wdata", bif.wdata, 32'd0);
        check("rst_addr", {12'd0, bif.ifmap_addr, bif.weight_addr, bif.bias_addr}, 32'd0);

        rst              = 1'b1;
        bif.ready        = 1'b0;
        bif.compute_done = 1'b0;
        quiet = 0;
        repeat (5) begin
            tick();
            quiet += int'(bif.ifmap_we) + int'(bif.weight_we) + int'(bif.bias_we) + int'(bif.busy);
        end
        check("idle_quiet", 32'(quiet), 32'd0);

        // Pass 0 of layer
        run_load(1'b0, -1, -1, -1);
        check("p0_err", {31'd0, bif.protocol_err}, 32'd0);
        finish_pass(1'b0, 1'b1);

        // compute_done while idle must be ignored
        bif.compute_done = 1'b1;
        tick();
        bif.compute_done = 1'b0;
        tick();
        check("idle_done_busy", {31'd0, bif.busy}, 32'd0);
        check("idle_done_pass", {31'd0, bif.pass_idx}, 32'd1);

        // Pass 1 with spurious done during weight load
        run_load(1'b1, -1, 200, -1);
        finish_pass(1'b1, 1'b0);

        // Extra ready mid-load
        run_load(1'b0, 500, -1, -1);
        check("err_set", {31'd0, bif.protocol_err}, 32'd1);
        finish_pass(1'b0, 1'b1);
        check("err_sticky", {31'd0, bif.protocol_err}, 32'd1);

        // Reset inside weight segment, then a clean restart
        run_load(1'b1, -1, -1, 300);
        repeat (2) tick();
        check("post_abort_idle", {31'd0, bif.busy}, 32'd0);
        run_load(1'b0, -1, -1, -1);
        check("restart_err", {31'd0, bif.protocol_err}, 32'd0);
        finish_pass(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/glb_load_sequencer.md
Name: glb_load_sequencer

Overview:
Sequences the 32-bit host input stream into the global buffers and triggers each accelerator pass. After each `ready` start pulse it counts the incoming words and routes them in order: ifmap words to the ifmap SRAM, weight words to the weight SRAM, bias words to the bias SRAM. It then pulses `compute_start` to the Controller and waits for `compute_done`. It sits between the top-level `data_in`/`ready` interface and the sram_ifmap/sram_weight/sram_bias write ports; it supports two passes per layer, i.e. two 64-output halves.

Parameters:
IFMAP_WORDS, 16, 32-bit ifmap words per pass (64 int8 values)
WEIGHT_WORDS, 1024, 32-bit weight words per pass (64x64 int8 values)
BIAS_WORDS, 64, 32-bit bias words per pass
NUM_PASS, 2, passes per layer before `layer_done`

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
ready  in  1  host start pulse; one cycle; begins a pass load
data_in  in  32  stream word; valid every cycle for exactly 1104 cycles after `ready`
compute_done  in  1  Controller pulse: pass finished
wdata  out  32  registered copy of the sampled `data_in`
ifmap_we  out  1  ifmap SRAM write enable
ifmap_addr  out  4  ifmap word address
weight_we  out  1  weight SRAM write enable
weight_addr  out  10  weight word address
bias_we  out  1  bias SRAM write enable
bias_addr  out  6  bias word address
compute_start  out  1  one-cycle pass start pulse to Controller
pass_idx  out  1  current pass (0 or 1)
busy  out  1  high in every state except IDLE
layer_done  out  1  one-cycle pulse after the final pass completes
protocol_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE; all outputs 0; word counter=0; pass_idx=0; protocol_err=0. Reset applied mid-load or mid-wait aborts the pass; no further writes occur.
- All outputs are registered.
- States: IDLE, LOAD_IF, LOAD_W, LOAD_B, START, WAIT_DONE.
- IDLE: `ready` sampled high at edge T0 -> LOAD_IF, counter=0. `compute_done` in IDLE is ignored.
- Stream timing: word k (k=0..1103) is sampled at edge T0+1+k. The matching write strobe is high in the cycle after the sampling edge, with `wdata`=word k. There is no back-pressure; exactly one write strobe is high per load cycle.
- LOAD_IF: k=0..15 -> ifmap_we, ifmap_addr=k. After k=15 -> LOAD_W.
- LOAD_W: k=16..1039 -> weight_we, weight_addr=k-16. After k=1039 -> LOAD_B.
- LOAD_B: k=1040..1103 -> bias_we, bias_addr=k-1040. After k=1103 -> START.
- Segment counters restart at 0 on each transition; addresses never wrap within a segment.
- START: lasts one cycle. `compute_start`=1 in the cycle immediately after the last `bias_we` cycle. Next state is WAIT_DONE.
- WAIT_DONE: on `compute_done`:
  - if pass_idx < NUM_PASS-1: pass_idx increments and state returns to IDLE (wait for the next `ready`);
  - else: pass_idx=0, `layer_done`=1 for one cycle, state returns to IDLE.
- Protocol errors: `ready` high while busy sets protocol_err; the sequence continues unaffected. `compute_done` in any state other than WAIT_DONE is ignored and does not set the error.
- Simultaneous events:
  - `ready` in the same cycle a pass returns to IDLE is ignored; `ready` is only honoured when sampled in IDLE.
  - `compute_done` coincident with the START cycle is ignored.
- `busy` falls in the same cycle the state enters IDLE.

Test Plan:
1. Reset values: hold rst=0 for 2 cycles with `ready`=1 and `compute_done`=1 -> all outputs 0, state IDLE. Release rst -> no writes until a fresh `ready` pulse.
2. Single pass routing: `ready` pulse, then data_in=k for k=0..1103. Required response:
   - ifmap addr 0..15 receive data 0..15;
   - weight addr 0 receives 16, addr 1023 receives 1039;
   - bias addr 0 receives 1040, addr 63 receives 1103;
   - exactly 1104 write strobes;
   - `compute_start` high exactly one cycle, 1105 cycles after the `ready` sampling edge + 1;
   - `busy`=1 throughout.
3. Two-pass layer: pass 0 completes with `compute_done` -> pass_idx=1, busy=0, no `layer_done`. Second `ready` plus 1104 words, then `compute_done` -> `layer_done` one cycle, pass_idx=0.
4. Protocol error: extra `ready` pulse at k=500 -> protocol_err=1 and stays set. Addresses and `compute_start` timing are identical to scenario 2.
5. Reset mid-load: rst=0 at k=300 (weight segment) -> all strobes 0 next cycle, state IDLE. A new `ready` restarts at ifmap_addr 0 with pass_idx 0.
6. Spurious done: `compute_done` pulsed during LOAD_W and in IDLE -> ignored, no state change. A later `compute_done` in WAIT_DONE is still required to advance.
